uart_serial_interface: RTL and testbench



---
 rtl/serial_if_pkg.sv | 23 ++
 rtl/serial_rx.sv | 97 +++++++++
 rtl/uart_serial_interface.sv | 117 +++++++++++
 tb/tb_uart_serial_interface.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_if_pkg.sv
// Shared types and constants for the 8N1 UART endpoint (uart_serial_interface and serial_rx).
package serial_if_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 2;   // start + data + stop

    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_rx.sv
// UART receiver: pin synchronizer, RX FSM and shift register; emits a byte plus a one-cycle strobe.
// With SERIAL_IF_STOP_CHECK_EN defined it also reports a framing error alongside the strobe.
module serial_rx
    import serial_if_pkg::*;
#(
    parameter logic [15:0] WTIME = 16'h0364
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_strobe
`ifdef SERIAL_IF_STOP_CHECK_EN
    ,
    output logic                 frame_err
`endif
);

    localparam logic [15:0] BIT_LAST  = WTIME - 16'd1;
    localparam logic [15:0] HALF_LAST = (WTIME >> 1) - 16'd1;

    rx_state_t             state, state_next;
    logic [1:0]            sync_q;
    logic                  line_s;
    logic                  line_prev;
    logic [15:0]           cnt;
    logic [2:0]            idx;
    logic [DATA_BITS-1:0]  shift;
    logic                  bit_end;
    logic                  half_end;

    assign line_s   = sync_q[1];
    assign bit_end  = (cnt == BIT_LAST);
    assign half_end = (cnt == HALF_LAST);
    assign rx_data  = shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_strobe <= 1'b0;
`ifdef SERIAL_IF_STOP_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], line};
            line_prev <= line_s;
            state     <= state_next;
            rx_strobe <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                end
                RX_START: cnt <= half_end ? '0 : cnt + 16'd1;
                RX_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        shift <= {line_s, shift[DATA_BITS-1:1]};
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        rx_strobe <= 1'b1;
`ifdef SERIAL_IF_STOP_CHECK_EN
                        frame_err <= ~line_s;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Edge detect against line_prev so a stuck-low line (bad stop bit) cannot retrigger a frame.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (line_prev && !line_s) state_next = RX_START;
            RX_START: if (half_end) state_next = line_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && idx == LAST_BIT_IDX) state_next = RX_STOP;
            RX_STOP:  if (bit_end) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_serial_interface.sv
// Full-duplex 8N1 UART endpoint with valid/ready byte streams; TX FSM and RX output register live here.
// Optional SERIAL_IF_STOP_CHECK_EN: drop received frames whose stop bit samples low.
module uart_serial_interface
    import serial_if_pkg::*;
#(
    parameter logic [15:0] WTIME = 16'h0364
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_txd_in,
    output logic                 uart_rxd_out,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 o_ready
);

    localparam logic [15:0] BIT_LAST = WTIME - 16'd1;

    tx_state_t             tx_state, tx_state_next;
    logic [15:0]           tx_cnt;
    logic [2:0]            tx_idx;
    logic [DATA_BITS-1:0]  tx_byte;
    logic                  tx_bit_end;

    logic [DATA_BITS-1:0]  rx_data;
    logic                  rx_strobe;
    logic                  rx_accept;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
        end else begin
            tx_state <= tx_state_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_idx <= '0;
                if (i_valid) tx_byte <= i_data;
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) tx_idx <= tx_idx + 3'd1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // NOTE: default assignment first in every always_comb, so no path leaves a latch behind.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (i_valid) tx_state_next = TX_START;
            TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx == LAST_BIT_IDX) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        i_ready      = 1'b0;
        uart_rxd_out = 1'b1;
        case (tx_state)
            TX_IDLE:  i_ready = 1'b1;
            TX_START: uart_rxd_out = 1'b0;
            TX_DATA:  uart_rxd_out = tx_byte[tx_idx];
            default:  uart_rxd_out = 1'b1;
        endcase
    end

`ifdef SERIAL_IF_STOP_CHECK_EN
    logic frame_err;

    serial_rx #(.WTIME(WTIME)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .line      (uart_txd_in),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    assign rx_accept = rx_strobe && !frame_err;
`else
    serial_rx #(.WTIME(WTIME)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .line      (uart_txd_in),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

    assign rx_accept = rx_strobe;
`endif

    // A byte arriving while o_valid is held is an overrun and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end else if (rx_accept && !o_valid) begin
            o_valid <= 1'b1;
            o_data  <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_serial_interface.sv
// Self-checking bench: instance A transmits into instance B; B's receive pin can be taken over by the bench.
module tb_uart_serial_interface;
    import serial_if_pkg::*;

    localparam logic [15:0] W16 = 16'h0030;
    localparam int W = 48;
    localparam int FRAME_CYC = FRAME_BITS * W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a_i_data = 8'h00;
    logic       a_i_valid = 1'b0;
    logic       a_i_ready;
    logic [7:0] a_o_data;
    logic       a_o_valid;
    logic       a_o_ready = 1'b1;
    logic       a_tx_pin;

    logic [7:0] b_i_data = 8'h00;
    logic       b_i_valid = 1'b0;
    logic       b_i_ready;
    logic [7:0] b_o_data;
    logic       b_o_valid;
    logic       b_o_ready = 1'b1;
    logic       b_tx_pin;
    logic       b_rx_pin;

    logic bench_line = 1'b1;
    logic use_bench  = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];

    assign b_rx_pin = use_bench ? bench_line : a_tx_pin;

    uart_serial_interface #(.WTIME(W16)) dut_a (
        .clk(clk), .rst(rst), .uart_txd_in(b_tx_pin), .uart_rxd_out(a_tx_pin),
        .i_data(a_i_data), .i_valid(a_i_valid), .i_ready(a_i_ready),
        .o_data(a_o_data), .o_valid(a_o_valid), .o_ready(a_o_ready)
    );

    uart_serial_interface #(.WTIME(W16)) dut_b (
        .clk(clk), .rst(rst), .uart_txd_in(b_rx_pin), .uart_rxd_out(b_tx_pin),
        .i_data(b_i_data), .i_valid(b_i_valid), .i_ready(b_i_ready),
        .o_data(b_o_data), .o_valid(b_o_valid), .o_ready(b_o_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every handshake on B's output side is one delivered byte.
    always @(negedge clk) begin
        if (b_o_valid === 1'b1 && b_o_ready === 1'b1) rx_q.push_back(b_o_data);
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the accepting edge, i.e. inside the first start-bit cycle.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        step(1);
        while (a_i_ready !== 1'b1 && n < 20 * W) begin
            step(1);
            n++;
        end
        if (n >= 20 * W) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: i_ready=%b after %0d cycles, required 1", a_i_ready, n);
        end
        a_i_data  = b;
        a_i_valid = 1'b1;
        step(1);
        a_i_valid = 1'b0;
        a_i_data  = 8'($urandom);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        use_bench = 1'b1;
        for (int i = 0; i < FRAME_BITS; i++) begin
            bench_line = frame[i];
            step(W);
        end
        bench_line = 1'b1;
        step(W);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_tx_pin !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", a_tx_pin); end
        checks++;
        if (a_i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b required 1", a_i_ready); end
        checks++;
        if (b_o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b required 0", b_o_valid); end
        checks++;
        if (b_o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data: got %h required 00", b_o_data); end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_tx_pin !== 1'b1 || b_tx_pin !== 1'b1 || b_o_valid !== 1'b0 || a_o_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_quiet: %0d active cycles, required 0", bad); end
    endtask

    // Expected pin level for cycle c after acceptance is frame bit c/W of {stop, data, start}.
    task automatic test_tx_frame(input logic [7:0] b);
        logic [9:0] frame;
        int bad_bit[FRAME_BITS];
        int bad_ready = 0;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) bad_bit[i] = 0;
        send_byte(b);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            if (a_tx_pin !== frame[c / W]) bad_bit[c / W]++;
            if (a_i_ready !== 1'b0) bad_ready++;
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            checks++;
            if (bad_bit[i] != 0) begin
                errors++;
                $display("FAIL tx_bit%0d byte %h: %0d cycles wrong, required level %b", i, b, bad_bit[i], frame[i]);
            end
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL tx_ready_low byte %h: i_ready high in %0d of %0d busy cycles, required 0", b, bad_ready, FRAME_CYC);
        end
        @(negedge clk);
        checks++;
        if (a_i_ready !== 1'b1 || a_tx_pin !== 1'b1) begin
            errors++;
            $display("FAIL tx_end byte %h: i_ready=%b txd=%b, required 1 1", b, a_i_ready, a_tx_pin);
        end
    endtask

    task automatic test_tx();
        rx_q.delete();
        test_tx_frame(8'h55);
        test_tx_frame(8'($urandom));
        step(W);
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q[$];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.delete();
        b_o_ready = 1'b1;
        foreach (exp_q[i]) begin
            send_byte(exp_q[i]);
            step(748);
        end
        step(200);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL loopback_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL loopback_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int acc_cyc[$];
        int n;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom));
        rx_q.delete();
        step(1);
        foreach (exp_q[i]) begin
            n = 0;
            while (a_i_ready !== 1'b1 && n < 20 * W) begin
                step(1);
                n++;
            end
            a_i_data  = exp_q[i];
            a_i_valid = 1'b1;
            acc_cyc.push_back(cyc);
            step(1);
        end
        a_i_valid = 1'b0;
        step(FRAME_CYC + 100);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != FRAME_CYC + 1) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles required %0d", i, acc_cyc[i] - acc_cyc[i-1], FRAME_CYC + 1);
            end
        end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_overrun();
        rx_q.delete();
        b_o_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        step(11 * W);
        @(negedge clk);
        checks++;
        if (b_o_valid !== 1'b1 || b_o_data !== 8'hA5) begin
            errors++;
            $display("FAIL overrun_hold: o_valid=%b o_data=%h, required 1 a5", b_o_valid, b_o_data);
        end
        step(1);
        b_o_ready = 1'b1;
        step(1);
        b_o_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (b_o_valid !== 1'b0) begin errors++; $display("FAIL overrun_clear: o_valid=%b required 0", b_o_valid); end
        step(2 * W);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || b_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drop: %0d bytes delivered, o_valid=%b, required 1 byte a5 and 0", rx_q.size(), b_o_valid);
        end
        b_o_ready = 1'b1;
    endtask

    task automatic test_glitch_framing();
        logic [7:0] b;
        rx_q.delete();
        use_bench  = 1'b1;
        bench_line = 1'b1;
        step(10);
        bench_line = 1'b0;
        step(12);
        bench_line = 1'b1;
        step(3 * W);
        checks++;
        if (rx_q.size() != 0 || b_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch: %0d bytes, o_valid=%b, required 0 0", rx_q.size(), b_o_valid);
        end
        rx_q.delete();
        drive_rx_frame(8'h81, 1'b0);
        step(W);
`ifdef SERIAL_IF_STOP_CHECK_EN
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL framing_drop: got %0d bytes required 0", rx_q.size());
        end
`else
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
            errors++;
            $display("FAIL framing_keep: got %0d bytes first %h, required 1 byte 81",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            rx_q.delete();
            b = 8'($urandom);
            drive_rx_frame(b, 1'b1);
            checks++;
            if (rx_q.size() != 1 || rx_q[0] !== b) begin
                errors++;
                $display("FAIL rx_direct%0d: got %0d bytes first %h, required 1 byte %h",
                         i, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
            end
        end
        use_bench = 1'b0;
        step(W);
    endtask

    task automatic test_reset_mid_frame();
        rx_q.delete();
        send_byte(8'hF0);
        step(4 * W + W / 2);
        @(negedge clk);
        checks++;
        if (a_tx_pin !== 1'b0) begin errors++; $display("FAIL midreset_bit3: txd=%b required 0", a_tx_pin); end
        step(1);
        rst = 1'b1;
        step(1);
        checks++;
        if (a_tx_pin !== 1'b1) begin errors++; $display("FAIL midreset_line: txd=%b required 1", a_tx_pin); end
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_i_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: i_ready=%b required 1", a_i_ready); end
        step(W);
        rx_q.delete();
        test_tx_frame(8'h0F);
        step(W);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h0F) begin
            errors++;
            $display("FAIL midreset_rx: got %0d bytes first %h, required 1 byte 0f",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_glitch_framing();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
